pipe_ctrl: RTL and testbench
============================

// Module: pipe_ctrl
// PURPOSE
//   Pipeline stall/flush controller for the 5-stage core. Receives stall
//   requests from the ID and EX stages, sequences multi-cycle EX operations
//   (mult/div), and drives the per-stage stall vector and the flush strobe.
//   Also keeps a saturating stall-cycle counter for performance debug.
// PARAMETERS
//   MC_CNT_W      6   width of the multi-cycle length input and down-counter
//   FLUSH_CYCLES  1   cycles flush_o stays high per flush request (>=1)
// PORTS
//   clk             in   1         core clock, all state on rising edge
//   rst             in   1         reset, synchronous, active-high
//   stallreq_id_i   in   1         ID hazard (load-use) stall request
//   stallreq_ex_i   in   1         EX single-cycle stall request
//   mc_start_i      in   1         EX issues a multi-cycle op this cycle
//   mc_len_i        in   MC_CNT_W  total EX cycles of that op
//   flush_req_i     in   1         exception/redirect flush request
//   stall_o         out  6         [0]pc [1]if [2]id [3]ex [4]mem [5]wb; 1 = hold
//   flush_o         out  1         clear IF/ID/EX pipeline registers
//   mc_busy_o       out  1         multi-cycle op in progress
//   mc_done_o       out  1         1-cycle pulse: final EX cycle of op, result valid
//   stall_cycles_o  out  32        saturating count of cycles with stall_o != 0
// BEHAVIOUR
//   - State: IDLE, BUSY, FLUSH (registered); cnt (MC_CNT_W bits); fcnt.
//   - rst high: next state IDLE, cnt=0, fcnt=0, stall_cycles_o=0; while rst is
//     high, stall_o=0, flush_o=0, mc_busy_o=0, mc_done_o=0 (outputs gated).
//   - stall_o is combinational from state + inputs. Priority, high to low:
//     flush_req_i -> 6'b000000; BUSY (cnt>1) -> 6'b001111;
//     IDLE & mc_start_i & mc_len_i>=2 -> 6'b001111; stallreq_ex_i -> 6'b001111;
//     stallreq_id_i -> 6'b000111; else 6'b000000.
//   - IDLE: mc_start_i & mc_len_i>=2 -> BUSY, cnt=mc_len_i-1.
//     mc_start_i & mc_len_i in {0,1} -> stay IDLE, mc_done_o=1 same cycle.
//   - BUSY: mc_busy_o=1; cnt decrements each cycle. Cycle with cnt==1:
//     mc_done_o=1, MC stall released (lower-priority requests still apply),
//     next state IDLE. Total stall cycles per op = mc_len_i-1.
//     mc_start_i while BUSY is ignored.
//   - flush_req_i in any state (wins over simultaneous mc_start_i): stall_o=0
//     that cycle, next state FLUSH, fcnt=FLUSH_CYCLES. An op in BUSY is
//     aborted: no mc_done_o pulse, cnt cleared.
//   - FLUSH: flush_o=1, stall_o=0, mc_start_i and stallreqs ignored; fcnt
//     decrements, exit to IDLE after FLUSH_CYCLES cycles. flush_req_i in
//     FLUSH reloads fcnt=FLUSH_CYCLES.
//   - flush_o is registered: first high cycle is the cycle after flush_req_i.
//   - stall_cycles_o increments when stall_o!=0, saturates at 32'hFFFF_FFFF
//     (never wraps); cleared only by rst.
//   - mc_len_i sampled only in the start cycle; later changes have no effect.
// TESTING
//   1 reset: assert rst 2 cycles mid-BUSY -> all outputs 0, state IDLE,
//     stall_cycles_o=0 on release.
//   2 mc_start_i=1, mc_len_i=5 in IDLE -> stall_o=6'b001111 for 4 cycles,
//     mc_done_o pulses in 5th cycle, mc_busy_o high cycles 2-5, counter +4.
//   3 stallreq_id_i=1 alone -> stall_o=6'b000111; with stallreq_ex_i=1 too
//     -> 6'b001111.
//   4 flush_req_i in 3rd BUSY cycle of mc_len_i=8 -> stall_o=0 that cycle,
//     flush_o high next FLUSH_CYCLES cycles, no mc_done_o, then IDLE.
//   5 mc_start_i with mc_len_i=1 and 0 -> no stall, mc_done_o same cycle.
//   6 force stall_cycles_o to 32'hFFFF_FFFE, hold stallreq_ex_i 3 cycles
//     -> reads 32'hFFFF_FFFF, no wrap.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// Stall/flush control bundle between the core's hazard sources and pipe_ctrl.
// Signal names keep the controller's point of view (_i into the controller, _o out of it).
interface pipe_ctrl_if #(
   parameter int MC_CNT_W = 6
);
   // No valid/ready handshake: every request is a level sampled on each rising
   // clock edge, and every output is a per-cycle level (mc_done_o is a 1-cycle pulse).
   logic                stallreq_id_i;
   logic                stallreq_ex_i;
   logic                mc_start_i;
   logic [MC_CNT_W-1:0] mc_len_i;
   logic                flush_req_i;
   logic [5:0]          stall_o;
   logic                flush_o;
   logic                mc_busy_o;
   logic                mc_done_o;
   logic [31:0]         stall_cycles_o;
   logic [1:0]          state_o;

   modport master (
      output stallreq_id_i, stallreq_ex_i, mc_start_i, mc_len_i, flush_req_i,
      input  stall_o, flush_o, mc_busy_o, mc_done_o, stall_cycles_o, state_o
   );

   modport slave (
      input  stallreq_id_i, stallreq_ex_i, mc_start_i, mc_len_i, flush_req_i,
      output stall_o, flush_o, mc_busy_o, mc_done_o, stall_cycles_o, state_o
   );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: sequences multi-cycle EX ops, drives the
// per-stage stall vector and flush strobe, and counts stalled cycles.
module pipe_ctrl #(
   parameter int MC_CNT_W     = 6,
   parameter int FLUSH_CYCLES = 1
) (
   input logic       clk,
   input logic       rst,
   pipe_ctrl_if.slave bus
);
   localparam int FCNT_W = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);
   localparam logic [FCNT_W-1:0] FCNT_INIT = FCNT_W'(FLUSH_CYCLES);
   localparam logic [5:0] STALL_EX = 6'b001111;
   localparam logic [5:0] STALL_ID = 6'b000111;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      FLUSH = 2'd2
   } state_t;

   state_t              state;
   logic [MC_CNT_W-1:0] cnt;
   logic [FCNT_W-1:0]   fcnt;
   logic [31:0]         stall_cnt;

   logic       start_long;
   logic       start_short;
   logic [5:0] stall_v;
   logic       done_v;

   assign start_long  = bus.mc_start_i && (bus.mc_len_i >= MC_CNT_W'(2));
   assign start_short = bus.mc_start_i && (bus.mc_len_i <  MC_CNT_W'(2));

   // Outputs are forced low while rst is held, whatever the registered state says.
   always_comb begin
      stall_v = 6'b000000;
      done_v  = 1'b0;
      if (!rst && !bus.flush_req_i && state != FLUSH) begin
         if (state == BUSY && cnt > MC_CNT_W'(1))
            stall_v = STALL_EX;
         else if (state == IDLE && start_long)
            stall_v = STALL_EX;
         else if (bus.stallreq_ex_i)
            stall_v = STALL_EX;
         else if (bus.stallreq_id_i)
            stall_v = STALL_ID;
         done_v = (state == IDLE && start_short) ||
                  (state == BUSY && cnt == MC_CNT_W'(1));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         fcnt      <= '0;
         stall_cnt <= '0;
      end else begin
         if (stall_v != 6'b000000 && stall_cnt != 32'hFFFF_FFFF)
            stall_cnt <= stall_cnt + 32'd1;

         // A flush aborts any op in flight and restarts the flush window.
         if (bus.flush_req_i) begin
            state <= FLUSH;
            fcnt  <= FCNT_INIT;
            cnt   <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (start_long) begin
                     state <= BUSY;
                     cnt   <= bus.mc_len_i - MC_CNT_W'(1);
                  end
               end
               BUSY: begin
                  if (cnt <= MC_CNT_W'(1)) begin
                     state <= IDLE;
                     cnt   <= '0;
                  end else begin
                     cnt <= cnt - MC_CNT_W'(1);
                  end
               end
               FLUSH: begin
                  if (fcnt <= FCNT_W'(1)) begin
                     state <= IDLE;
                     fcnt  <= '0;
                  end else begin
                     fcnt <= fcnt - FCNT_W'(1);
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign bus.stall_o        = stall_v;
   assign bus.mc_done_o      = done_v;
   assign bus.mc_busy_o      = !rst && (state == BUSY);
   assign bus.flush_o        = !rst && (state == FLUSH);
   assign bus.stall_cycles_o = stall_cnt;
   assign bus.state_o        = state;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed, table-driven bench for pipe_ctrl: one vector per clock cycle plus
// a hand-written saturation sequence for the stall-cycle counter.
module tb_pipe_ctrl;
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_BUSY  = 2'd1;
   localparam logic [1:0] S_FLUSH = 2'd2;

   logic clk = 1'b0;
   logic rst = 1'b1;

   pipe_ctrl_if #(.MC_CNT_W(6)) bif ();

   pipe_ctrl #(.MC_CNT_W(6), .FLUSH_CYCLES(1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       id;
      logic       ex;
      logic       st;
      logic [5:0] len;
      logic       fl;
      logic [5:0] stall;
      logic       flush;
      logic       busy;
      logic       done;
      logic [1:0] state;
   } vec_t;

   vec_t vq[$];
   int   checks = 0;
   int   errors = 0;
   logic [31:0] cnt_model = 32'd0;

   task automatic add(input logic r, input logic id, input logic ex, input logic st,
                      input logic [5:0] len, input logic fl, input logic [5:0] stall,
                      input logic flush, input logic busy, input logic done,
                      input logic [1:0] state);
      vec_t v;
      v.rst = r; v.id = id; v.ex = ex; v.st = st; v.len = len; v.fl = fl;
      v.stall = stall; v.flush = flush; v.busy = busy; v.done = done; v.state = state;
      vq.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic id, input logic ex, input logic st,
                        input logic [5:0] len, input logic fl);
      rst               = r;
      bif.stallreq_id_i = id;
      bif.stallreq_ex_i = ex;
      bif.mc_start_i    = st;
      bif.mc_len_i      = len;
      bif.flush_req_i   = fl;
   endtask

   initial begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
      repeat (3) @(posedge clk);

      //   rst id ex st len fl | stall      fo busy done state
      add(1, 0, 0, 0, 6'd0, 0, 6'b000000, 0, 0, 0, S_IDLE);
      // ID / EX single-cycle stall requests
      add(0, 1, 0, 0, 6'd0, 0, 6'b000111, 0, 0, 0, S_IDLE);
      add(0, 1, 1, 0, 6'd0, 0, 6'b001111, 0, 0, 0, S_IDLE);
      add(0, 0, 1, 0, 6'd0, 0, 6'b001111, 0, 0, 0, S_IDLE);
      add(0, 0, 0, 0, 6'd0, 0, 6'b000000, 0, 0, 0, S_IDLE);
      // len=5 op; len change and re-start while busy are ignored
      add(0, 0, 0, 1, 6'd5, 0, 6'b001111, 0, 0, 0, S_IDLE);
      add(0, 0, 0, 1, 6'd9, 0, 6'b001111, 0, 1, 0, S_BUSY);
      add(0, 0, 0, 0, 6'd9, 0, 6'b001111, 0, 1, 0, S_BUSY);
      add(0, 0, 0, 0, 6'd9, 0, 6'b001111, 0, 1, 0, S_BUSY);
      add(0, 0, 0, 0, 6'd0, 0, 6'b000000, 0, 1, 1, S_BUSY);
      add(0, 0, 0, 0, 6'd0, 0, 6'b000000, 0, 0, 0, S_IDLE);
      // len=3 op; ID request shows through in the final op cycle
      add(0, 0, 0, 1, 6'd3, 0, 6'b001111, 0, 0, 0, S_IDLE);
      add(0, 0, 0, 0, 6'd0, 0, 6'b001111, 0, 1, 0, S_BUSY);
      add(0, 1, 0, 0, 6'd0, 0, 6'b000111, 0, 1, 1, S_BUSY);
      add(0, 0, 0, 0, 6'd0, 0, 6'b000000, 0, 0, 0, S_IDLE);
      // short ops complete in the start cycle
      add(0, 0, 0, 1, 6'd1, 0, 6'b000000, 0, 0, 1, S_IDLE);
      add(0, 0, 0, 1, 6'd0, 0, 6'b000000, 0, 0, 1, S_IDLE);
      add(0, 0, 1, 1, 6'd1, 0, 6'b001111, 0, 0, 1, S_IDLE);
      // len=8 op flushed in its 3rd BUSY cycle
      add(0, 0, 0, 1, 6'd8, 0, 6'b001111, 0, 0, 0, S_IDLE);
      add(0, 0, 0, 0, 6'd0, 0, 6'b001111, 0, 1, 0, S_BUSY);
      add(0, 0, 0, 0, 6'd0, 0, 6'b001111, 0, 1, 0, S_BUSY);
      add(0, 0, 0, 0, 6'd0, 1, 6'b000000, 0, 1, 0, S_BUSY);
      add(0, 0, 1, 1, 6'd2, 0, 6'b000000, 1, 0, 0, S_FLUSH);
      add(0, 0, 0, 0, 6'd0, 0, 6'b000000, 0, 0, 0, S_IDLE);
      // flush beats start; flush inside FLUSH reloads the window
      add(0, 0, 0, 1, 6'd4, 1, 6'b000000, 0, 0, 0, S_IDLE);
      add(0, 0, 0, 0, 6'd0, 1, 6'b000000, 1, 0, 0, S_FLUSH);
      add(0, 0, 0, 0, 6'd0, 0, 6'b000000, 1, 0, 0, S_FLUSH);
      add(0, 1, 0, 0, 6'd0, 0, 6'b000111, 0, 0, 0, S_IDLE);
      // flush beats a short start: no done pulse
      add(0, 0, 0, 1, 6'd1, 1, 6'b000000, 0, 0, 0, S_IDLE);
      add(0, 0, 0, 0, 6'd0, 0, 6'b000000, 1, 0, 0, S_FLUSH);
      add(0, 0, 0, 0, 6'd0, 0, 6'b000000, 0, 0, 0, S_IDLE);
      // reset held 2 cycles mid-BUSY gates every output
      add(0, 0, 0, 1, 6'd6, 0, 6'b001111, 0, 0, 0, S_IDLE);
      add(0, 0, 0, 0, 6'd0, 0, 6'b001111, 0, 1, 0, S_BUSY);
      add(1, 1, 1, 1, 6'd6, 1, 6'b000000, 0, 0, 0, S_BUSY);
      add(1, 0, 0, 0, 6'd0, 0, 6'b000000, 0, 0, 0, S_IDLE);
      add(0, 0, 0, 0, 6'd0, 0, 6'b000000, 0, 0, 0, S_IDLE);
      // minimum multi-cycle length
      add(0, 0, 0, 1, 6'd2, 0, 6'b001111, 0, 0, 0, S_IDLE);
      add(0, 0, 0, 0, 6'd0, 0, 6'b000000, 0, 1, 1, S_BUSY);
      add(0, 0, 0, 0, 6'd0, 0, 6'b000000, 0, 0, 0, S_IDLE);

      for (int i = 0; i < vq.size(); i++) begin
         @(negedge clk);
         drive(vq[i].rst, vq[i].id, vq[i].ex, vq[i].st, vq[i].len, vq[i].fl);
         #1;
         check($sformatf("v%0d stall", i), 32'(bif.stall_o), 32'(vq[i].stall));
         check($sformatf("v%0d flush", i), 32'(bif.flush_o), 32'(vq[i].flush));
         check($sformatf("v%0d busy", i),  32'(bif.mc_busy_o), 32'(vq[i].busy));
         check($sformatf("v%0d done", i),  32'(bif.mc_done_o), 32'(vq[i].done));
         check($sformatf("v%0d state", i), 32'(bif.state_o), 32'(vq[i].state));
         check($sformatf("v%0d stall_cycles", i), bif.stall_cycles_o, cnt_model);
         if (vq[i].rst)
            cnt_model = 32'd0;
         else if (vq[i].stall != 6'b000000)
            cnt_model = cnt_model + 32'd1;
      end

      // Counter saturation near the top of its range
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
      force dut.stall_cnt = 32'hFFFF_FFFE;
      #1;
      release dut.stall_cnt;
      #1;
      check("sat preload", bif.stall_cycles_o, 32'hFFFF_FFFE);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         drive(1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0);
         #1;
         check($sformatf("sat stall %0d", k), 32'(bif.stall_o), 32'h0000_000F);
         check($sformatf("sat count %0d", k), bif.stall_cycles_o,
               (k == 0) ? 32'hFFFF_FFFE : 32'hFFFF_FFFF);
      end
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
      #1;
      check("sat final", bif.stall_cycles_o, 32'hFFFF_FFFF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
